// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory controller:
//   - load/store opcode constants (instruction bits [31:26])
//   - access-size enum and controller FSM state enum
//   - opcode decode and misalignment helpers
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_LB = 6'b100000;
    localparam logic [5:0] OP_LH = 6'b100001;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_CAPTURE,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic  legal;
        logic  load;
        logic  store;
        size_e size;
    } op_dec_t;

    function automatic op_dec_t decode_op(input logic [5:0] op);
        op_dec_t d;
        d = '{legal: 1'b0, load: 1'b0, store: 1'b0, size: SZ_WORD};
        case (op)
            OP_LW:   d = '{legal: 1'b1, load: 1'b1, store: 1'b0, size: SZ_WORD};
            OP_LH:   d = '{legal: 1'b1, load: 1'b1, store: 1'b0, size: SZ_HALF};
            OP_LB:   d = '{legal: 1'b1, load: 1'b1, store: 1'b0, size: SZ_BYTE};
            OP_SW:   d = '{legal: 1'b1, load: 1'b0, store: 1'b1, size: SZ_WORD};
            OP_SH:   d = '{legal: 1'b1, load: 1'b0, store: 1'b1, size: SZ_HALF};
            OP_SB:   d = '{legal: 1'b1, load: 1'b0, store: 1'b1, size: SZ_BYTE};
            default: d = '{legal: 1'b0, load: 1'b0, store: 1'b0, size: SZ_WORD};
        endcase
        return d;
    endfunction

    // Word accesses need lane 0; halfword accesses need an even lane.
    function automatic logic misaligned(input size_e size, input logic [1:0] lane);
        return ((size == SZ_WORD) && (lane != 2'b00)) ||
               ((size == SZ_HALF) && lane[0]);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational little-endian lane logic shared by the store and load paths.
//   size      in  access size (byte/half/word)
//   lane      in  byte address bits [1:0]
//   wdata     in  raw store data (rt)
//   rdata     in  raw SRAM read word
//   be        out store byte enables, bit i = byte lane i
//   wdata_rep out store data replicated across all lanes
//   rdata_ext out selected load lane, sign-extended to 32 bits
// Halfword accesses use lane[1] only; word accesses ignore lane.
// -----------------------------------------------------------------------------
module mem_lane_align
    import dmem_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be        = '1;
        wdata_rep = wdata;
        rdata_ext = rdata;
        byte_sel  = rdata[{lane, 3'b000} +: 8];
        half_sel  = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be        = 4'b0011 << {lane[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                be        = '1;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Memory-side responder for lw/lh/lb/sw/sh/sb. Accepts one request at a time
// and drives a synchronous single-port word-wide SRAM.
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_op/addr/wdata     opcode [31:26], byte address, store data
//   busy                  high whenever the FSM is not IDLE
//   resp_valid            one-cycle completion pulse
//   resp_rdata/resp_err   load result (0 for stores/errors), error flag;
//                         both hold until the next response
//   sram_en/we/be/addr/wdata  registered SRAM controls
//   sram_rdata            SRAM read data, valid the cycle after last sram_en
// Parameters: MEM_AW (word-address width), WAIT_CYCLES (extra hold cycles).
// Build option: DMEM_MISALIGN_TRAP_EN traps misaligned lw/sw/lh/sh with
// resp_err instead of silently ignoring the low address bits.
// -----------------------------------------------------------------------------
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_AW      = 10,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              sram_en,
    output logic              sram_we,
    output logic [3:0]        sram_be,
    output logic [MEM_AW-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    size_e             size_q, size_d;
    logic [1:0]        lane_q, lane_d;
    logic              load_q, load_d;
    logic              sram_en_q, sram_en_d;
    logic              sram_we_q, sram_we_d;
    logic [3:0]        sram_be_q, sram_be_d;
    logic [MEM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [31:0]       sram_wdata_q, sram_wdata_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    op_dec_t     dec;
    logic        trap;
    size_e       al_size;
    logic [1:0]  al_lane;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        unused_addr_hi;

    assign dec            = decode_op(req_op);
    assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap = misaligned(dec.size, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    // One aligner serves both paths: it sees the incoming request while IDLE
    // (store steering) and the latched size/lane in CAPTURE (load extract).
    assign al_size = (state_q == ST_CAPTURE) ? size_q : dec.size;
    assign al_lane = (state_q == ST_CAPTURE) ? lane_q : req_addr[1:0];

    mem_lane_align u_align (
        .size      (al_size),
        .lane      (al_lane),
        .wdata     (req_wdata),
        .rdata     (sram_rdata),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        size_d       = size_q;
        lane_d       = lane_q;
        load_d       = load_q;
        sram_en_d    = sram_en_q;
        sram_we_d    = sram_we_q;
        sram_be_d    = sram_be_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    size_d = dec.size;
                    lane_d = req_addr[1:0];
                    load_d = dec.load;
                    cnt_d  = '0;
                    if (dec.legal && !trap) begin
                        state_d      = ST_ACCESS;
                        sram_en_d    = 1'b1;
                        sram_we_d    = dec.store;
                        sram_addr_d  = req_addr[MEM_AW+1:2];
                        sram_be_d    = dec.store ? al_be : '1;
                        sram_wdata_d = dec.store ? al_wdata : '0;
                    end else begin
                        state_d      = ST_RESP;
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == WAIT_LAST) begin
                    sram_en_d = 1'b0;
                    sram_we_d = 1'b0;
                    if (load_q) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        state_d      = ST_RESP;
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_CAPTURE: begin
                state_d      = ST_RESP;
                resp_rdata_d = al_rdata;
                resp_err_d   = 1'b0;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            size_q       <= SZ_WORD;
            lane_q       <= '0;
            load_q       <= 1'b0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_be_q    <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            size_q       <= size_d;
            lane_q       <= lane_d;
            load_q       <= load_d;
            sram_en_q    <= sram_en_d;
            sram_we_q    <= sram_we_d;
            sram_be_q    <= sram_be_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign sram_en    = sram_en_q;
    assign sram_we    = sram_we_q;
    assign sram_be    = sram_be_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Two controllers: dut_a (WAIT_CYCLES=0) and dut_b (WAIT_CYCLES=2), each with
// its own behavioural SRAM. Expected results for dut_a come from a byte-array
// memory model updated by the bench's own store rules.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;
    import dmem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic mem_clr;

    logic        a_req_valid, a_req_ready, a_busy, a_resp_valid, a_resp_err;
    logic [5:0]  a_req_op;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic        a_sram_en, a_sram_we;
    logic [3:0]  a_sram_be;
    logic [9:0]  a_sram_addr;
    logic [31:0] a_sram_wdata, a_sram_rdata;

    logic        b_req_valid, b_req_ready, b_busy, b_resp_valid, b_resp_err;
    logic [5:0]  b_req_op;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic        b_sram_en, b_sram_we;
    logic [3:0]  b_sram_be;
    logic [9:0]  b_sram_addr;
    logic [31:0] b_sram_wdata, b_sram_rdata;

    data_mem_ctrl #(.MEM_AW(10), .WAIT_CYCLES(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_op(a_req_op),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .busy(a_busy),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .sram_en(a_sram_en), .sram_we(a_sram_we), .sram_be(a_sram_be),
        .sram_addr(a_sram_addr), .sram_wdata(a_sram_wdata), .sram_rdata(a_sram_rdata)
    );

    data_mem_ctrl #(.MEM_AW(10), .WAIT_CYCLES(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .busy(b_busy),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .sram_en(b_sram_en), .sram_we(b_sram_we), .sram_be(b_sram_be),
        .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata), .sram_rdata(b_sram_rdata)
    );

    // Behavioural synchronous SRAMs (environment, not the reference model).
    logic [31:0] a_mem [1024];
    logic [31:0] b_mem [1024];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) a_mem[i] <= '0;
        end else if (a_sram_en) begin
            if (a_sram_we) begin
                for (int i = 0; i < 4; i++)
                    if (a_sram_be[i]) a_mem[a_sram_addr][8*i +: 8] <= a_sram_wdata[8*i +: 8];
            end else begin
                a_sram_rdata <= a_mem[a_sram_addr];
            end
        end
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) b_mem[i] <= '0;
        end else if (b_sram_en) begin
            if (b_sram_we) begin
                for (int i = 0; i < 4; i++)
                    if (b_sram_be[i]) b_mem[b_sram_addr][8*i +: 8] <= b_sram_wdata[8*i +: 8];
            end else begin
                b_sram_rdata <= b_mem[b_sram_addr];
            end
        end
    end

    // Reference model: 4 KiB byte array (2^10 words), little-endian.
    logic [7:0] ref_mem [4096];
    int n_vec = 0;
    int n_bad = 0;

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OP_LW, OP_LH, OP_LB, OP_SW, OP_SH, OP_SB};
    endfunction

    function automatic bit is_store(input logic [5:0] op);
        return op inside {OP_SW, OP_SH, OP_SB};
    endfunction

    function automatic bit ref_trap(input logic [5:0] op, input logic [31:0] addr);
`ifdef DMEM_MISALIGN_TRAP_EN
        return ((op == OP_LW || op == OP_SW) && (addr % 4 != 0)) ||
               ((op == OP_LH || op == OP_SH) && (addr % 2 != 0));
`else
        return (op == 6'h3f) && (addr == 32'h1) && 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr);
        int unsigned ea, w, h;
        ea = addr % 4096;
        w  = ea - (ea % 4);
        h  = ea - (ea % 2);
        case (op)
            OP_LW:   return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
            OP_LH:   return {{16{ref_mem[h+1][7]}}, ref_mem[h+1], ref_mem[h]};
            OP_LB:   return {{24{ref_mem[ea][7]}}, ref_mem[ea]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic ref_store(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] d);
        int unsigned ea, w, h;
        ea = addr % 4096;
        w  = ea - (ea % 4);
        h  = ea - (ea % 2);
        case (op)
            OP_SB: ref_mem[ea] = d[7:0];
            OP_SH: begin ref_mem[h] = d[7:0]; ref_mem[h+1] = d[15:8]; end
            OP_SW: for (int unsigned k = 0; k < 4; k++) ref_mem[w+k] = d[8*k +: 8];
            default: ;
        endcase
    endtask

    // Issues one request and observes the controller until its response.
    // lat is the number of cycles from the accept edge to resp_valid (-1 on timeout).
    task automatic run_req(input bit on_b, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, output logic rdy, output logic [31:0] rd,
                           output logic er, output int lat, output int en_n, output int we_n,
                           output logic [3:0] be, output logic [9:0] sa, output logic [31:0] swd,
                           output bit stable);
        rd = '0; er = 1'b0; lat = -1; en_n = 0; we_n = 0; be = '0; sa = '0; swd = '0; stable = 1'b1;
        @(negedge clk);
        rdy = on_b ? b_req_ready : a_req_ready;
        if (on_b) begin
            b_req_valid = 1'b1; b_req_op = op; b_req_addr = addr; b_req_wdata = wd;
        end else begin
            a_req_valid = 1'b1; a_req_op = op; a_req_addr = addr; a_req_wdata = wd;
        end
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (on_b ? b_sram_en : a_sram_en) begin
                if (en_n > 0 && (be !== (on_b ? b_sram_be : a_sram_be) ||
                                 sa !== (on_b ? b_sram_addr : a_sram_addr))) stable = 1'b0;
                en_n++;
                be  = on_b ? b_sram_be : a_sram_be;
                sa  = on_b ? b_sram_addr : a_sram_addr;
                swd = on_b ? b_sram_wdata : a_sram_wdata;
                if (on_b ? b_sram_we : a_sram_we) we_n++;
            end
            if (on_b ? b_resp_valid : a_resp_valid) begin
                lat = c;
                rd  = on_b ? b_resp_rdata : a_resp_rdata;
                er  = on_b ? b_resp_err : a_resp_err;
                break;
            end
        end
    endtask

    logic        rdy, er;
    logic [31:0] rd, swd;
    int          lat, en_n, we_n;
    logic [3:0]  be;
    logic [9:0]  sa;
    bit          stable;

    task automatic test_reset();
        @(negedge clk);
        n_vec++; if ({a_req_ready, a_busy, a_resp_valid, a_resp_err} !== 4'b1000) begin
            n_bad++; $display("FAIL reset_ctl: got %b want 1000", {a_req_ready, a_busy, a_resp_valid, a_resp_err}); end
        n_vec++; if (a_resp_rdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_rdata: got %h want 0", a_resp_rdata); end
        n_vec++; if ({a_sram_en, a_sram_we, a_sram_be, a_sram_addr, a_sram_wdata} !== '0) begin
            n_bad++; $display("FAIL reset_sram: en=%b we=%b be=%b addr=%h wd=%h want all 0",
                              a_sram_en, a_sram_we, a_sram_be, a_sram_addr, a_sram_wdata); end
        n_vec++; if ({b_req_ready, b_busy, b_sram_en} !== 3'b100) begin
            n_bad++; $display("FAIL reset_b: got %b want 100", {b_req_ready, b_busy, b_sram_en}); end
    endtask

    task automatic test_store_load();
        run_req(0, OP_SW, 32'h10, 32'hDEADBEEF, rdy, rd, er, lat, en_n, we_n, be, sa, swd, stable);
        ref_store(OP_SW, 32'h10, 32'hDEADBEEF);
        n_vec++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL sw_ready: got %b want 1", rdy); end
        n_vec++; if (lat != 2) begin n_bad++; $display("FAIL sw_latency: got %0d want 2", lat); end
        n_vec++; if (en_n != 1 || we_n != 1) begin n_bad++; $display("FAIL sw_en: en=%0d we=%0d want 1/1", en_n, we_n); end
        n_vec++; if (sa !== 10'h4 || be !== 4'b1111) begin n_bad++; $display("FAIL sw_addr_be: got %h/%b want 004/1111", sa, be); end
        n_vec++; if (swd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_wdata: got %h want deadbeef", swd); end
        n_vec++; if (rd !== 32'h0 || er !== 1'b0) begin n_bad++; $display("FAIL sw_resp: got %h/%b want 0/0", rd, er); end
        run_req(0, OP_LW, 32'h10, 32'h0, rdy, rd, er, lat, en_n, we_n, be, sa, swd, stable);
        n_vec++; if (lat != 3) begin n_bad++; $display("FAIL lw_latency: got %0d want 3", lat); end
        n_vec++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_bad++; $display("FAIL lw_resp: got %h/%b want deadbeef/0", rd, er); end
        n_vec++; if (we_n != 0 || be !== 4'b1111 || sa !== 10'h4) begin
            n_bad++; $display("FAIL lw_sram: we=%0d be=%b addr=%h want 0/1111/004", we_n, be, sa); end
    endtask

    task automatic test_misalign();
        run_req(0, OP_LW, 32'h11, 32'h0, rdy, rd, er, lat, en_n, we_n, be, sa, swd, stable);
`ifdef DMEM_MISALIGN_TRAP_EN
        n_vec++; if (lat != 1 || en_n != 0) begin n_bad++; $display("FAIL mis_trap_timing: lat=%0d en=%0d want 1/0", lat, en_n); end
        n_vec++; if (rd !== 32'h0 || er !== 1'b1) begin n_bad++; $display("FAIL mis_trap_resp: got %h/%b want 0/1", rd, er); end
`else
        n_vec++; if (lat != 3 || sa !== 10'h4) begin n_bad++; $display("FAIL mis_lw_access: lat=%0d addr=%h want 3/004", lat, sa); end
        n_vec++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_bad++; $display("FAIL mis_lw_resp: got %h/%b want deadbeef/0", rd, er); end
`endif
    endtask

    task automatic test_byte_lanes();
        run_req(0, OP_SB, 32'h13, 32'h12345680, rdy, rd, er, lat, en_n, we_n, be, sa, swd, stable);
        ref_store(OP_SB, 32'h13, 32'h12345680);
        n_vec++; if (be !== 4'b1000 || swd !== 32'h80808080) begin
            n_bad++; $display("FAIL sb_lane: be=%b wd=%h want 1000/80808080", be, swd); end
        run_req(0, OP_LB, 32'h13, 32'h0, rdy, rd, er, lat, en_n, we_n, be, sa, swd, stable);
        n_vec++; if (rd !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_sext: got %h want ffffff80", rd); end
        run_req(0, OP_LB, 32'h10, 32'h0, rdy, rd, er, lat, en_n, we_n, be, sa, swd, stable);
        n_vec++; if (rd !== 32'hFFFFFFEF) begin n_bad++; $display("FAIL lb_lane0: got %h want ffffffef", rd); end
        run_req(0, OP_LB, 32'h11, 32'h0, rdy, rd, er, lat, en_n, we_n, be, sa, swd, stable);
        n_vec++; if (rd !== 32'hFFFFFFBE) begin n_bad++; $display("FAIL lb_lane1: got %h want ffffffbe", rd); end
    endtask

    task automatic test_halfword();
        run_req(0, OP_SH, 32'h22, 32'h00001234, rdy, rd, er, lat, en_n, we_n, be, sa, swd, stable);
        ref_store(OP_SH, 32'h22, 32'h00001234);
        n_vec++; if (be !== 4'b1100 || swd !== 32'h12341234) begin
            n_bad++; $display("FAIL sh_hi: be=%b wd=%h want 1100/12341234", be, swd); end
        run_req(0, OP_LH, 32'h22, 32'h0, rdy, rd, er, lat, en_n, we_n, be, sa, swd, stable);
        n_vec++; if (rd !== 32'h00001234) begin n_bad++; $display("FAIL lh_pos: got %h want 00001234", rd); end
        run_req(0, OP_SH, 32'h20, 32'h5555ABCD, rdy, rd, er, lat, en_n, we_n, be, sa, swd, stable);
        ref_store(OP_SH, 32'h20, 32'h5555ABCD);
        n_vec++; if (be !== 4'b0011) begin n_bad++; $display("FAIL sh_lo_be: got %b want 0011", be); end
        run_req(0, OP_LH, 32'h20, 32'h0, rdy, rd, er, lat, en_n, we_n, be, sa, swd, stable);
        n_vec++; if (rd !== 32'hFFFFABCD) begin n_bad++; $display("FAIL lh_neg: got %h want ffffabcd", rd); end
        run_req(0, OP_LW, 32'h20, 32'h0, rdy, rd, er, lat, en_n, we_n, be, sa, swd, stable);
        n_vec++; if (rd !== 32'h1234ABCD) begin n_bad++; $display("FAIL lw_halves: got %h want 1234abcd", rd); end
    endtask

    task automatic test_illegal();
        run_req(0, 6'b000000, 32'h10, 32'h0, rdy, rd, er, lat, en_n, we_n, be, sa, swd, stable);
        n_vec++; if (lat != 1 || en_n != 0) begin n_bad++; $display("FAIL ill_timing: lat=%0d en=%0d want 1/0", lat, en_n); end
        n_vec++; if (rd !== 32'h0 || er !== 1'b1) begin n_bad++; $display("FAIL ill_resp: got %h/%b want 0/1", rd, er); end
        // Response holds and the controller is idle on the following cycle.
        @(negedge clk);
        n_vec++; if ({a_resp_valid, a_resp_err, a_req_ready, a_busy} !== 4'b0110) begin
            n_bad++; $display("FAIL ill_after: got %b want 0110", {a_resp_valid, a_resp_err, a_req_ready, a_busy}); end
        run_req(0, 6'b100100, 32'h10, 32'h0, rdy, rd, er, lat, en_n, we_n, be, sa, swd, stable);
        n_vec++; if (er !== 1'b1 || en_n != 0) begin n_bad++; $display("FAIL ill_lbu: err=%b en=%0d want 1/0", er, en_n); end
    endtask

    task automatic test_alias();
        run_req(0, OP_SW, 32'h10000040, 32'hA5A5_0F0F, rdy, rd, er, lat, en_n, we_n, be, sa, swd, stable);
        ref_store(OP_SW, 32'h10000040, 32'hA5A5_0F0F);
        n_vec++; if (sa !== 10'h010) begin n_bad++; $display("FAIL alias_addr: got %h want 010", sa); end
        run_req(0, OP_LW, 32'hFFFFF040, 32'h0, rdy, rd, er, lat, en_n, we_n, be, sa, swd, stable);
        n_vec++; if (rd !== 32'hA5A50F0F) begin n_bad++; $display("FAIL alias_load: got %h want a5a50f0f", rd); end
    endtask

    task automatic test_back_to_back();
        int c;
        int w_cnt;
        logic [31:0] got;
        logic [31:0] exp;
        exp = ref_load(OP_LW, 32'h10);
        got = 'x;
        w_cnt = 0;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_op = OP_LW; a_req_addr = 32'h10; a_req_wdata = '0;
        @(posedge clk);
        #1;
        // Requester keeps valid high with different contents while busy.
        a_req_op = OP_SW; a_req_wdata = 32'h0;
        for (c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (a_sram_en && a_sram_we) w_cnt++;
            if (a_resp_valid) begin
                got = a_resp_rdata;
                n_vec++; if ({a_req_ready, a_busy} !== 2'b01) begin
                    n_bad++; $display("FAIL b2b_resp_ready: got %b want 01", {a_req_ready, a_busy}); end
                a_req_valid = 1'b0;
                break;
            end
        end
        n_vec++; if (c != 3 || got !== exp || w_cnt != 0) begin
            n_bad++; $display("FAIL b2b_held: lat=%0d rd=%h writes=%0d want 3/%h/0", c, got, w_cnt, exp); end
        @(negedge clk);
        n_vec++; if ({a_resp_valid, a_busy, a_resp_rdata} !== {2'b00, exp}) begin
            n_bad++; $display("FAIL b2b_pulse: valid=%b busy=%b rd=%h want 0/0/%h", a_resp_valid, a_busy, a_resp_rdata, exp); end
    endtask

    task automatic test_random();
        logic [5:0]  op;
        logic [31:0] addr, wd, exp_rd;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        int          exp_lat, exp_en;
        bit          bad;
        int unsigned ea;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 13))
                0, 6:  op = OP_LW;
                1, 7:  op = OP_LH;
                2, 8:  op = OP_LB;
                3, 9:  op = OP_SW;
                4, 10: op = OP_SH;
                5, 11: op = OP_SB;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (is_legal(op)) op = 6'($urandom_range(0, 63));
                end
            endcase
            addr = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
            wd   = $urandom;
            ea   = addr % 4096;
            exp_rd = '0; exp_be = 4'b1111; exp_wd = wd;
            if (!is_legal(op) || ref_trap(op, addr)) begin
                exp_lat = 1; exp_en = 0;
            end else if (is_store(op)) begin
                exp_lat = 2; exp_en = 1;
                if (op == OP_SB) begin exp_be = 4'(1 << (ea % 4)); exp_wd = 32'(wd[7:0]) * 32'h01010101; end
                if (op == OP_SH) begin exp_be = 4'(3 << (ea & 2)); exp_wd = 32'(wd[15:0]) * 32'h00010001; end
            end else begin
                exp_lat = 3; exp_en = 1;
                exp_rd = ref_load(op, addr);
            end
            run_req(0, op, addr, wd, rdy, rd, er, lat, en_n, we_n, be, sa, swd, stable);
            if (is_legal(op) && !ref_trap(op, addr) && is_store(op)) ref_store(op, addr, wd);
            bad = (lat != exp_lat) || (en_n != exp_en) || (rd !== exp_rd) ||
                  (er !== (exp_en == 0)) ||
                  (we_n != ((exp_en == 1 && is_store(op)) ? 1 : 0));
            if (exp_en == 1)
                bad = bad || (be !== exp_be) || (sa !== 10'(ea / 4)) ||
                      (is_store(op) && swd !== exp_wd);
            n_vec++;
            if (bad) begin
                n_bad++;
                $display("FAIL rand%0d op=%b addr=%h: got lat=%0d en=%0d we=%0d rd=%h err=%b be=%b sa=%h wd=%h want lat=%0d en=%0d rd=%h be=%b sa=%h wd=%h",
                         i, op, addr, lat, en_n, we_n, rd, er, be, sa, swd,
                         exp_lat, exp_en, exp_rd, exp_be, 10'(ea / 4), exp_wd);
            end
        end
    endtask

    task automatic test_wait_cycles();
        run_req(1, OP_SW, 32'h30, 32'hCAFEF00D, rdy, rd, er, lat, en_n, we_n, be, sa, swd, stable);
        n_vec++; if (lat != 4 || en_n != 3 || we_n != 3) begin
            n_bad++; $display("FAIL w2_sw: lat=%0d en=%0d we=%0d want 4/3/3", lat, en_n, we_n); end
        n_vec++; if (sa !== 10'h00C || be !== 4'b1111 || !stable) begin
            n_bad++; $display("FAIL w2_sw_sram: addr=%h be=%b stable=%0d want 00c/1111/1", sa, be, stable); end
        run_req(1, OP_LW, 32'h30, 32'h0, rdy, rd, er, lat, en_n, we_n, be, sa, swd, stable);
        n_vec++; if (lat != 5 || en_n != 3 || we_n != 0 || !stable) begin
            n_bad++; $display("FAIL w2_lw_timing: lat=%0d en=%0d we=%0d stable=%0d want 5/3/0/1", lat, en_n, we_n, stable); end
        n_vec++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            n_bad++; $display("FAIL w2_lw_resp: got %h/%b want cafef00d/0", rd, er); end
    endtask

    task automatic test_reset_mid();
        int resp_seen;
        resp_seen = 0;
        @(negedge clk);
        b_req_valid = 1'b1; b_req_op = OP_LW; b_req_addr = 32'h30; b_req_wdata = '0;
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (b_sram_en !== 1'b1) begin n_bad++; $display("FAIL rmid_inflight: sram_en=%b want 1", b_sram_en); end
        rst_n = 1'b0;
        #1;
        n_vec++; if ({b_sram_en, b_busy, b_req_ready, b_sram_addr, b_sram_be} !== {3'b001, 10'h0, 4'h0}) begin
            n_bad++; $display("FAIL rmid_clear: en=%b busy=%b ready=%b addr=%h be=%b want 0/0/1/000/0000",
                              b_sram_en, b_busy, b_req_ready, b_sram_addr, b_sram_be); end
        repeat (2) begin @(negedge clk); if (b_resp_valid) resp_seen++; end
        rst_n = 1'b1;
        repeat (6) begin @(negedge clk); if (b_resp_valid) resp_seen++; end
        n_vec++; if (resp_seen != 0) begin n_bad++; $display("FAIL rmid_noresp: got %0d responses want 0", resp_seen); end
        run_req(1, OP_LW, 32'h30, 32'h0, rdy, rd, er, lat, en_n, we_n, be, sa, swd, stable);
        n_vec++; if (lat != 5 || rd !== 32'hCAFEF00D) begin
            n_bad++; $display("FAIL rmid_recover: lat=%0d rd=%h want 5/cafef00d", lat, rd); end
    endtask

    initial begin
        rst_n   = 1'b0;
        mem_clr = 1'b1;
        a_req_valid = 1'b0; a_req_op = '0; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = 1'b0; b_req_op = '0; b_req_addr = '0; b_req_wdata = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1 mem_clr = 1'b0;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_store_load();
        test_misalign();
        test_byte_lanes();
        test_halfword();
        test_illegal();
        test_alias();
        test_back_to_back();
        test_random();
        test_wait_cycles();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Memory-side responder for the load/store instructions the main decoder flags with MemRead/MemWrite: lw, lb, lh, sw, sb, sh.
- Accepts one request at a time from the datapath and drives a synchronous single-port word-wide SRAM.
- Performs byte-lane steering and byte-enable generation on stores, and lane extraction with sign extension on loads.
- Returns a one-cycle response pulse; busy stalls the pipeline while a request is in flight.

Parameters:
- MEM_AW, 10, SRAM word-address width (depth 2^MEM_AW words).
- WAIT_CYCLES, 0, extra cycles sram_en/sram_addr are held per access (range 0..7).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_op  in  6  instruction opcode [31:26].
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rt).
- busy  out  1  high whenever state != IDLE.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, extended; 0 for stores/errors.
- resp_err  out  1  valid with resp_valid; illegal op or trapped misalign.
- sram_en  out  1  SRAM access enable.
- sram_we  out  1  SRAM write.
- sram_be  out  4  byte enables, bit i = byte lane i.
- sram_addr  out  MEM_AW  word address = req_addr[MEM_AW+1:2].
- sram_wdata  out  32  lane-replicated store data.
- sram_rdata  in  32  read data, valid the cycle after the last sram_en cycle.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values: req_ready=1, busy=0, resp_valid=0, resp_rdata=0, resp_err=0, sram_en=0, sram_we=0, sram_be=0, sram_addr=0, sram_wdata=0. All SRAM outputs are registered.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: req_ready=1. On accept, latch op/addr/wdata and decode.
  - Legal, non-trapped op -> ACCESS.
  - Otherwise -> RESP with err=1.
- ACCESS: sram_en=1 for exactly WAIT_CYCLES+1 cycles; sram_addr and sram_be are stable throughout. sram_we=1 for all of those cycles on stores.
  - Then: stores -> RESP; loads -> CAPTURE.
- CAPTURE: sample sram_rdata, extract the lane, extend, register into resp_rdata -> RESP.
- RESP: resp_valid=1 for one cycle, then -> IDLE. req_ready=0 in this state, so no same-cycle accept.
- Latency (WAIT_CYCLES=0, accept at cycle T):
  - Store: sram_en at T+1, resp_valid at T+2.
  - Load: sram_en at T+1, sram_rdata at T+2, resp_valid at T+3.
  - Error: resp_valid at T+1.
- Endianness: little-endian. lane = addr[1:0].
  - sb: be = 4'b0001<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - sh: be = 4'b0011<<{addr[1],1'b0}; wdata = {2{wdata[15:0]}}.
  - sw: be = 4'b1111.
  - Loads: be = 4'b1111.
- Loads: lb/lh sign-extend the selected byte/halfword; lw returns the full word.
- Address wrap: address bits above MEM_AW+1 are ignored, so accesses alias modulo 2^MEM_AW words.
- Illegal opcode (not one of the six): no SRAM activity, resp_err=1, resp_rdata=0.
- req_valid while busy: ignored; the requester holds the request.
- resp_rdata and resp_err hold their value until the next response.
- Reset mid-operation: immediate return to IDLE, all SRAM outputs cleared, no response for the in-flight request. A store caught mid-ACCESS may or may not have been written.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: lw/sw with addr[1:0]!=0, or lh/sh with addr[0]!=0, makes no SRAM access and responds err=1, rdata=0, at T+1.
- Undefined: low address bits are silently ignored (lw/sw word-aligned, lh/sh use addr[1]); resp_err only for illegal opcodes.

Decomposition:
- Package dmem_pkg holds:
  - opcode constants OP_LW=6'b100011, OP_LB=6'b100000, OP_LH=6'b100001, OP_SW=6'b101011, OP_SB=6'b101000, OP_SH=6'b101001;
  - size enum SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state enum.
- Sub-module mem_lane_align (combinational): size, addr[1:0], wdata/rdata -> be, replicated wdata, extended rdata. It is shared between the store and load paths.

Test Plan:
- Store then load: sw 0xDEADBEEF @0x10 -> sram_addr=4, be=1111. Then lw @0x10 -> resp_rdata=0xDEADBEEF at T+3, err=0.
- Byte lanes: sb 0x80 @0x13 -> be=1000, sram_wdata=0x80808080. Then lb @0x13 -> 0xFFFFFF80.
- Halfword: sh 0x1234 @0x22 -> be=1100; lh @0x22 -> 0x00001234. sh 0xABCD @0x20, lh -> 0xFFFFABCD.
- Illegal op 6'b000000 -> resp_valid at T+1, err=1, sram_en never asserted.
- Misaligned lw @0x11:
  - With DMEM_MISALIGN_TRAP_EN -> err=1 at T+1, no sram_en.
  - Without -> reads word 4, err=0.
- WAIT_CYCLES=2, lw: sram_en high exactly 3 cycles, resp_valid at T+5. Reset asserted during ACCESS -> sram_en low immediately, no resp_valid, next request serviced normally.
